cart_dump: RTL and testbench



---
 rtl/cart_dump.sv | 186 ++++++++++++++++++
 tb/tb_cart_dump.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_dump.sv
// MBC1 cartridge ROM dumper: walks every bank through the Game Boy bus and sends each byte as an 8N1 UART frame.
// Define CART_DUMP_CHECKSUM_EN to append a mod-256 sum frame; OFFSET_W narrows the per-bank window for short simulations.
module cart_dump #(
    parameter int CLKS_PER_BIT = 36,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = 2,
    parameter int OFFSET_W     = 14
) (
    input  logic        clockgb,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] address,
    output logic [7:0]  outdata,
    input  logic [7:0]  indata,
    output logic        load,
    output logic        store,
    output logic        UART_TX
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST    = LAT_W'(READ_LATENCY - 1);
    localparam logic [1:0]        LAST_BANK   = 2'(NUM_BANKS - 1);
    localparam logic [13:0]       LAST_OFFSET = 14'((1 << OFFSET_W) - 1);

    typedef enum logic [2:0] {
        IDLE, SETBANK, SETTLE, READ, TX_START, TX_DATA, TX_STOP, FINISH
    } state_t;

    state_t            state;
    logic [1:0]        bank;
    logic [13:0]       offset;
    logic [BAUD_W-1:0] baud_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
`ifdef CART_DUMP_CHECKSUM_EN
    logic [7:0]        sum;
    logic              sum_frame;
`endif

    // Bank 0 must use the fixed 0x0000 window: MBC1 aliases bank 0 to bank 1 at 0x4000.
    function automatic logic [15:0] window(input logic [1:0] b, input logic [13:0] off);
        return (b == 2'd0) ? {2'b00, off} : (16'h4000 | {2'b00, off});
    endfunction

    always_ff @(posedge clockgb) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            load     <= 1'b0;
            store    <= 1'b0;
            address  <= 16'h0000;
            outdata  <= 8'h00;
            UART_TX  <= 1'b1;
            bank     <= 2'd0;
            offset   <= 14'd0;
            baud_cnt <= '0;
            lat_cnt  <= '0;
            bit_idx  <= 3'd0;
`ifdef CART_DUMP_CHECKSUM_EN
            sum       <= 8'h00;
            sum_frame <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        bank    <= 2'd0;
                        offset  <= 14'd0;
                        address <= 16'h0000;
                        load    <= 1'b1;
                        lat_cnt <= '0;
                        state   <= READ;
`ifdef CART_DUMP_CHECKSUM_EN
                        sum       <= 8'h00;
                        sum_frame <= 1'b0;
`endif
                    end
                end
                SETBANK: begin
                    store <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    address <= window(bank, offset);
                    load    <= 1'b1;
                    lat_cnt <= '0;
                    state   <= READ;
                end
                READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        shreg    <= indata;
                        load     <= 1'b0;
                        UART_TX  <= 1'b0;
                        baud_cnt <= '0;
                        state    <= TX_START;
`ifdef CART_DUMP_CHECKSUM_EN
                        sum <= sum + indata;
`endif
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                TX_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        UART_TX  <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_idx  <= 3'd0;
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                TX_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            UART_TX <= 1'b1;
                            state   <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            UART_TX <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                TX_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
`ifdef CART_DUMP_CHECKSUM_EN
                        if (sum_frame) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end else if (bank == LAST_BANK && offset == LAST_OFFSET) begin
                            shreg     <= sum;
                            sum_frame <= 1'b1;
                            UART_TX   <= 1'b0;
                            state     <= TX_START;
                        end else
`else
                        if (bank == LAST_BANK && offset == LAST_OFFSET) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end else
`endif
                        if (offset == LAST_OFFSET) begin
                            bank    <= bank + 2'd1;
                            offset  <= 14'd0;
                            address <= 16'h2000;
                            outdata <= {6'b000000, bank + 2'd1};
                            store   <= 1'b1;
                            state   <= SETBANK;
                        end else begin
                            offset  <= offset + 14'd1;
                            address <= window(bank, offset + 14'd1);
                            load    <= 1'b1;
                            lat_cnt <= '0;
                            state   <= READ;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_dump.sv
// Bench for cart_dump: MBC1 bus model plus UART receiver, checked against a byte-stream reference model.
`timescale 1ns/1ps
module tb_cart_dump;

    localparam int CPB    = 4;
    localparam int NB     = 2;
    localparam int LAT    = 3;
    localparam int OW     = 4;
    localparam int BB     = 1 << OW;
    localparam int NBYTES = NB * BB;
`ifdef CART_DUMP_CHECKSUM_EN
    localparam int NFR = NBYTES + 1;
`else
    localparam int NFR = NBYTES;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  indata = 8'h00;
    logic        busy, done, load, store, UART_TX;
    logic [15:0] address;
    logic [7:0]  outdata;

    cart_dump #(
        .CLKS_PER_BIT(CPB),
        .NUM_BANKS(NB),
        .READ_LATENCY(LAT),
        .OFFSET_W(OW)
    ) dut (
        .clockgb(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .address(address),
        .outdata(outdata),
        .indata(indata),
        .load(load),
        .store(store),
        .UART_TX(UART_TX)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0]  data;
        logic        stop;
        logic [31:0] low;
        logic [31:0] st;
    } frame_t;

    frame_t      rx_q[$];
    logic [15:0] rd_q[$];
    int          lr_q[$];
    logic [23:0] st_q[$];
    int          gap_q[$];
    logic [7:0]  mem [0:NBYTES-1];
    int          bankreg = 1;

    int rx_act = 0, rx_cnt = 0, rx_st = 0, rx_low = 0, rx_inlow = 0;
    logic [7:0] rx_data = 8'h00;
    int lrun = 0, both = 0, unstable = 0, st_pend = 0, st_cyc = 0;
    int done_n = 0, done_cyc = 0, done_busy = 0, busy_lo = 0, trk = 0;
    logic [15:0] rd_addr = 16'h0000;

    // Monitors and the cartridge bus model, all sampled mid-cycle.
    always @(negedge clk) begin
        int b;
        if (!rx_act) begin
            if (UART_TX === 1'b0) begin
                rx_act = 1; rx_cnt = 0; rx_st = cyc; rx_low = 1; rx_inlow = 1; rx_data = 8'h00;
            end
        end else begin
            rx_cnt++;
            if (rx_inlow != 0) begin
                if (UART_TX === 1'b0) rx_low++;
                else rx_inlow = 0;
            end
            for (int k = 0; k < 8; k++)
                if (rx_cnt == CPB * (k + 1) + CPB / 2) rx_data[k] = UART_TX;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back({rx_data, UART_TX, 32'(rx_low), 32'(rx_st)});
                rx_act = 0;
            end
        end

        if (load && store) both++;
        if (store) begin
            st_q.push_back({address, outdata});
            st_cyc = cyc;
            st_pend = 1;
            bankreg = (outdata[1:0] == 2'd0) ? 1 : int'(outdata[1:0]);
        end
        if (load) begin
            if (lrun == 0) begin
                rd_q.push_back(address);
                rd_addr = address;
                if (st_pend != 0) begin
                    gap_q.push_back(cyc - st_cyc);
                    st_pend = 0;
                end
            end else if (address !== rd_addr) begin
                unstable++;
            end
            lrun++;
        end else if (lrun != 0) begin
            lr_q.push_back(lrun);
            lrun = 0;
        end
        b = (address >= 16'h4000) ? (bankreg % NB) : 0;
        if (load && lrun == LAT) indata = mem[b * BB + int'(address[OW-1:0])];
        else indata = 8'($urandom);

        if (trk != 0) begin
            if (done) trk = 0;
            else if (!busy) busy_lo++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
            done_busy = busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete(); rd_q.delete(); lr_q.delete(); st_q.delete(); gap_q.delete();
        rx_act = 0; lrun = 0; both = 0; unstable = 0; st_pend = 0;
        done_n = 0; busy_lo = 0; trk = 0;
    endtask

    function automatic logic [15:0] exp_addr(input int i);
        int b = i / BB;
        int off = i % BB;
        return (b == 0) ? 16'(off) : (16'h4000 | 16'(off));
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_dump(input int mode);
        int t0, n, tz, espace, got;
        logic [7:0] d, csum;
        csum = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (mode == 0) mem[i] = exp_addr(i)[7:0] ^ 8'(i / BB);
            else mem[i] = 8'($urandom);
            csum = csum + mem[i];
        end
        bankreg = 1;
        clear_mon();
        pulse_start();
        t0 = cyc;
        trk = 1;
        chk("busy_after_start", busy, 1);
        for (int w = 0; w < 2000 && rx_q.size() < 5; w++) @(posedge clk);
        pulse_start();
        got = 0;
        for (int w = 0; w < 20000; w++) begin
            @(posedge clk);
            if (done_n > 0) begin got = 1; break; end
        end
        chk("done_seen", got, 1);
        repeat (60) @(posedge clk);
        #1;

        chk("frame_count", rx_q.size(), NFR);
        n = (rx_q.size() < NFR) ? rx_q.size() : NFR;
        for (int i = 0; i < n; i++) begin
            d = (i < NBYTES) ? mem[i] : csum;
            chk($sformatf("frame%0d_data", i), rx_q[i].data, d);
            chk($sformatf("frame%0d_stop", i), rx_q[i].stop, 1);
            tz = 0;
            while (tz < 8 && d[tz] == 1'b0) tz++;
            chk($sformatf("frame%0d_lowrun", i), rx_q[i].low, CPB * (1 + tz));
            if (i == 0) begin
                espace = LAT;
                chk("first_frame_latency", rx_q[0].st - t0, espace);
            end else begin
                espace = 10 * CPB;
                if (i < NBYTES) espace += LAT + ((i % BB == 0) ? 2 : 0);
                chk($sformatf("frame%0d_spacing", i), rx_q[i].st - rx_q[i-1].st, espace);
            end
        end
        chk("read_count", rd_q.size(), NBYTES);
        chk("load_run_count", lr_q.size(), NBYTES);
        for (int i = 0; i < NBYTES && i < rd_q.size(); i++)
            chk($sformatf("read%0d_addr", i), rd_q[i], exp_addr(i));
        for (int i = 0; i < lr_q.size(); i++)
            chk($sformatf("load%0d_len", i), lr_q[i], LAT);
        chk("addr_stable", unstable, 0);
        chk("load_store_exclusive", both, 0);
        chk("store_count", st_q.size(), NB - 1);
        for (int i = 0; i < st_q.size(); i++)
            chk($sformatf("store%0d", i), st_q[i], {16'h2000, 8'(i + 1)});
        chk("settle_gap_count", gap_q.size(), NB - 1);
        for (int i = 0; i < gap_q.size(); i++)
            chk($sformatf("settle%0d_gap", i), gap_q[i], 2);
        chk("done_pulses", done_n, 1);
        chk("busy_at_done", done_busy, 0);
        if (rx_q.size() > 0) chk("done_timing", done_cyc - rx_q[rx_q.size()-1].st, 10 * CPB);
        chk("busy_held", busy_lo, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int got;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uart", UART_TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load", load, 0);
        chk("rst_store", store, 0);
        chk("rst_addr", address, 0);
        chk("rst_outdata", outdata, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        run_dump(0);
        run_dump(1);

        clear_mon();
        for (int i = 0; i < NBYTES; i++) mem[i] = 8'h00;
        pulse_start();
        got = 0;
        for (int w = 0; w < 2000; w++) begin
            @(posedge clk);
            if (rx_act != 0 && rx_cnt >= 2 * CPB + 1) begin got = 1; break; end
        end
        chk("reached_tx_data", got, 1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_uart", UART_TX, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_load", load, 0);
        chk("midrst_store", store, 0);
        chk("midrst_addr", address, 0);
        chk("midrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (60) @(posedge clk);
        clear_mon();
        repeat (60) @(posedge clk);
        #1;
        chk("postrst_no_frames", rx_q.size(), 0);
        chk("postrst_no_reads", rd_q.size(), 0);
        chk("postrst_idle", busy, 0);
        chk("postrst_uart", UART_TX, 1);

        run_dump(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
